set_job_arbiter: RTL and testbench
==================================

SET_JOB_ARBITER -- requirements
Module: set_job_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023, max cycles WAIT may last before abort.
REQ-002 SHALL have parameter ID_W, default 1, requester-index width; fixed at two requesters.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  2  per-requester job request level, bit i = requester i.
REQ-006 SHALL have port req_central  input  2x24  per-requester packed centres {xa,ya,xb,yb,xc,yc}, 4 b each.
REQ-007 SHALL have port req_radius  input  2x12  per-requester radii {ra,rb,rc}, 4 b each.
REQ-008 SHALL have port req_mode  input  2x2  per-requester set mode 0..3.
REQ-009 SHALL have port gnt  output  2  one-cycle one-hot pulse: operands of that requester captured.
REQ-010 SHALL have port eng_en  output  1  start pulse to the SET engine.
REQ-011 SHALL have ports eng_central / eng_radius / eng_mode  output  24/12/2  registered operands to the engine.
REQ-012 SHALL have port eng_busy  input  1  engine busy flag.
REQ-013 SHALL have port eng_valid  input  1  engine result strobe.
REQ-014 SHALL have port eng_candidate  input  8  engine result count.
REQ-015 SHALL have port rsp_valid  output  1  one-cycle result strobe.
REQ-016 SHALL have port rsp_id  output  ID_W  requester owning the response.
REQ-017 SHALL have port rsp_candidate  output  8  captured count.
REQ-018 SHALL have port rsp_err  output  1  qualifies rsp_valid; 1 = timeout, rsp_candidate = 0.

Function
REQ-019 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if req != 0 and eng_busy == 0, SHALL pick winner, capture its operands into eng_* regs, pulse gnt[winner], record owner, go ISSUE; else stay.
REQ-021 Arbitration SHALL be round-robin: pointer favours the requester not served last; a single request is always granted; both requesting and pointer = 0 -> requester 0 wins.
REQ-022 Pointer SHALL update only in RESP, to the other requester of the completed owner, including on error.
REQ-023 ISSUE: eng_en = 1 for exactly one cycle, then go WAIT.
REQ-024 WAIT: on eng_valid = 1, capture eng_candidate, go RESP with rsp_err = 0.
REQ-025 WAIT: timeout counter starts at 0 on WAIT entry, increments each WAIT cycle; when it reaches TIMEOUT_CYC with no eng_valid, go RESP with rsp_err = 1, candidate 0.
REQ-026 eng_valid in the same cycle the counter reaches TIMEOUT_CYC SHALL win: normal response, no error.
REQ-027 RESP: rsp_valid = 1 for one cycle with rsp_id = owner; next state IDLE.
REQ-028 Grant-to-response latency SHALL be 2 + (engine cycles) + 1 cycles, with no added bubbles.
REQ-029 eng_valid outside WAIT SHALL be ignored: no response, no state change.
REQ-030 eng_central/eng_radius/eng_mode SHALL stay stable from capture until the next grant, including across IDLE.
REQ-031 req deassertion after gnt SHALL NOT cancel the in-flight job.
REQ-032 gnt, eng_en and rsp_valid SHALL be mutually exclusive in any cycle.
REQ-033 Only one job SHALL be in flight; no queueing beyond the captured operand registers.

Reset
REQ-034 rst SHALL asynchronously force IDLE, pointer = 0, timeout counter = 0, and all outputs (gnt, eng_en, eng_*, rsp_*) to 0.
REQ-035 rst during WAIT SHALL drop the in-flight job silently with no rsp_valid; the engine is reset by the same rst.

Structure
REQ-036 FSM state encoding, the 24/12/2 operand widths and the default TIMEOUT_CYC SHALL live in shared package set_pkg.
REQ-037 A sub-module rr_arb2 (2-way round-robin pick, combinational, pointer input) SHALL be used; all other logic is flat.

Verification
REQ-038 Single job: req = 01, mode 0, central 0x440000, radius 0x200, engine model returns 13 -> gnt = 01, eng_en one cycle later, rsp_valid with id 0, candidate 13.
REQ-039 Contention: req = 11 held, pointer 0 -> grants go 0, 1, 0, 1; rsp_id alternates.
REQ-040 Busy gating: eng_busy = 1 while req = 10 -> no gnt until busy falls, gnt = 10 the next cycle.
REQ-041 Timeout: TIMEOUT_CYC = 8, engine never returns valid -> rsp_valid, rsp_err = 1, candidate 0, 8 cycles after WAIT entry; pointer advances.
REQ-042 Boundary: eng_valid on the exact cycle the counter hits TIMEOUT_CYC -> rsp_err = 0, candidate passed through.
REQ-043 Reset mid-WAIT: assert rst asynchronously -> all outputs 0 immediately, no rsp_valid after release, next req granted normally.

Source files
------------

// File: rtl/set_pkg.sv
// Shared definitions for the SET job arbiter.
// Holds the arbiter FSM encoding, the engine operand widths and the default
// WAIT timeout, so the arbiter, its sub-module and any bench agree on them.
package set_pkg;

    localparam int CENTRAL_W   = 24;   // {xa,ya,xb,yb,xc,yc}, 4 b each
    localparam int RADIUS_W    = 12;   // {ra,rb,rc}, 4 b each
    localparam int MODE_W      = 2;    // set mode 0..3
    localparam int CAND_W      = 8;    // engine result count
    localparam int TIMEOUT_DEF = 1023; // default max WAIT cycles

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// Ports:
//   req  - request bits, bit i = requester i
//   ptr  - preferred requester when both request
//   gnt  - one-hot pick (zero when nobody requests)
//   win  - index of the picked requester (0 when nobody requests)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        gnt = 2'b00;
        if (req == 2'b11) begin
            win = ptr;
        end else if (req == 2'b10) begin
            win = 1'b1;
        end
        if (req != 2'b00) begin
            gnt = win ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/set_job_arbiter.sv
// Arbitrates two requesters onto a single SET engine, one job at a time.
// A winner's operands are latched into the eng_* registers, the engine is
// started with a one-cycle eng_en, and its result (or a timeout) is returned
// as a one-cycle rsp_valid tagged with the owner's index.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   req / req_central /
//   req_radius / req_mode       - per-requester job request and operands
//   gnt                         - one-hot grant pulse (operands captured)
//   eng_en, eng_central,
//   eng_radius, eng_mode        - engine start pulse and held operands
//   eng_busy, eng_valid,
//   eng_candidate               - engine status and result
//   rsp_valid, rsp_id,
//   rsp_candidate, rsp_err      - response strobe, owner, count, timeout flag
module set_job_arbiter
    import set_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    parameter int ID_W        = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     req,
    input  logic [1:0][CENTRAL_W-1:0]      req_central,
    input  logic [1:0][RADIUS_W-1:0]       req_radius,
    input  logic [1:0][MODE_W-1:0]         req_mode,
    output logic [1:0]                     gnt,
    output logic                           eng_en,
    output logic [CENTRAL_W-1:0]           eng_central,
    output logic [RADIUS_W-1:0]            eng_radius,
    output logic [MODE_W-1:0]              eng_mode,
    input  logic                           eng_busy,
    input  logic                           eng_valid,
    input  logic [CAND_W-1:0]              eng_candidate,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [CAND_W-1:0]              rsp_candidate,
    output logic                           rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state, state_nx;
    logic             ptr;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pick_gnt;
    logic             pick_win;
    logic             start;
    logic             timeout_hit;

    rr_arb2 u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .win (pick_win)
    );

    // cnt is 0 on the first WAIT cycle, so the cycle it would step to
    // TIMEOUT_CYC is the last WAIT cycle; an eng_valid there still wins.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        eng_en    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != 2'b00 && !eng_busy) begin
                    start    = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_en   = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_valid || timeout_hit) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Grant is a decode of IDLE plus live req; mask it so reset
        // forces it low immediately regardless of req.
        gnt = (start && !rst) ? pick_gnt : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= 1'b0;
            owner         <= 1'b0;
            cnt           <= '0;
            eng_central   <= '0;
            eng_radius    <= '0;
            eng_mode      <= '0;
            rsp_id        <= '0;
            rsp_candidate <= '0;
            rsp_err       <= 1'b0;
        end else begin
            // Operands are held until the next grant, across IDLE too.
            if (start) begin
                owner       <= pick_win;
                eng_central <= req_central[pick_win];
                eng_radius  <= req_radius[pick_win];
                eng_mode    <= req_mode[pick_win];
            end
            if (state == ST_ISSUE) begin
                cnt <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
                if (eng_valid) begin
                    rsp_id        <= ID_W'(owner);
                    rsp_candidate <= eng_candidate;
                    rsp_err       <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_id        <= ID_W'(owner);
                    rsp_candidate <= '0;
                    rsp_err       <= 1'b1;
                end
            end
            // Favour the other requester once a job completes, error or not.
            if (state == ST_RESP) begin
                ptr <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_set_job_arbiter.sv
// Scoreboard bench for set_job_arbiter with a small engine model.
module tb_set_job_arbiter;
    import set_pkg::*;

    localparam int T = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [1:0]                req;
    logic [1:0][CENTRAL_W-1:0] req_central;
    logic [1:0][RADIUS_W-1:0]  req_radius;
    logic [1:0][MODE_W-1:0]    req_mode;
    logic [1:0]                gnt;
    logic                      eng_en;
    logic [CENTRAL_W-1:0]      eng_central;
    logic [RADIUS_W-1:0]       eng_radius;
    logic [MODE_W-1:0]         eng_mode;
    logic                      eng_busy;
    logic                      eng_valid;
    logic [CAND_W-1:0]         eng_candidate;
    logic                      rsp_valid;
    logic [0:0]                rsp_id;
    logic [CAND_W-1:0]         rsp_candidate;
    logic                      rsp_err;
    logic                      ext_busy;
    logic                      run_busy;

    assign eng_busy = ext_busy | run_busy;

    set_job_arbiter #(.TIMEOUT_CYC(T), .ID_W(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_central(req_central),
        .req_radius(req_radius), .req_mode(req_mode), .gnt(gnt),
        .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius),
        .eng_mode(eng_mode), .eng_busy(eng_busy), .eng_valid(eng_valid),
        .eng_candidate(eng_candidate), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_candidate(rsp_candidate), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // expected response: owner, count, error flag, cycle it must appear in
    typedef struct {
        int id;
        int cand;
        int err;
        int at;
    } exp_t;
    exp_t sb[$];

    // reference state: one job at a time, pointer = other side of last owner
    logic                 m_ptr = 1'b0;
    logic                 m_inflight = 1'b0;
    logic                 m_owner = 1'b0;
    logic                 m_w;
    int                   m_gcyc = 0;
    int                   m_ngnt = 0;
    int                   m_nrsp = 0;
    logic [CENTRAL_W-1:0] m_c = '0;
    logic [RADIUS_W-1:0]  m_r = '0;
    logic [MODE_W-1:0]    m_m = '0;
    int                   glog[$];

    // engine forcing controls (directed cases)
    logic f_en;
    int   f_d;
    int   f_c;
    int   dly_tab[8] = '{0, 1, 2, 3, 5, T - 1, T, T + 3};

    // Engine model: d = WAIT cycles before the strobe (0 = first WAIT cycle).
    // d >= T means the job times out; the late strobe then lands outside WAIT.
    initial begin
        int   d, c;
        exp_t e;
        bit   ok;
        eng_valid     = 1'b0;
        eng_candidate = '0;
        run_busy      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_en && !rst) begin
                if (f_en) begin
                    d = f_d;
                    c = f_c;
                end else begin
                    d = dly_tab[$urandom_range(0, 7)];
                    c = int'($urandom_range(0, 255));
                end
                e.id   = int'(m_owner);
                e.err  = (d >= T) ? 1 : 0;
                e.cand = (d >= T) ? 0 : c;
                // grant at cyc-1; response 2 + engine cycles + 1 after it
                e.at   = (d >= T) ? (cyc - 1) + 2 + T : (cyc - 1) + 2 + d + 1;
                sb.push_back(e);
                run_busy = 1'b1;
                ok = 1'b1;
                for (int k = 0; k <= d; k++) begin
                    @(posedge clk);
                    #1;
                    if (rst) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (ok) begin
                    eng_valid     = 1'b1;
                    eng_candidate = 8'(c);
                    @(posedge clk);
                    #1;
                    eng_valid = 1'b0;
                end
                run_busy = 1'b0;
            end
        end
    end

    // Monitor: samples on the falling edge.
    always @(negedge clk) begin
        logic [1:0] eg;
        int         n;
        exp_t       e;
        if (rst) begin
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_eng_en", 32'(eng_en), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            m_inflight = 1'b0;
            m_ptr      = 1'b0;
            m_c        = '0;
            m_r        = '0;
            m_m        = '0;
            sb.delete();
        end else begin
            eg  = 2'b00;
            m_w = 1'b0;
            if (!m_inflight && req != 2'b00 && !eng_busy) begin
                m_w = (req == 2'b11) ? m_ptr : (req == 2'b10);
                eg  = m_w ? 2'b10 : 2'b01;
            end
            check("gnt", 32'(gnt), 32'(eg));
            n = int'(gnt != 2'b00) + int'(eng_en) + int'(rsp_valid);
            check("exclusive", 32'(n <= 1), 32'h1);
            check("eng_en", 32'(eng_en), 32'(m_inflight && cyc == m_gcyc + 1));
            check("eng_central", 32'(eng_central), 32'(m_c));
            check("eng_radius", 32'(eng_radius), 32'(m_r));
            check("eng_mode", 32'(eng_mode), 32'(m_m));
            if (eg != 2'b00) begin
                m_inflight = 1'b1;
                m_owner    = m_w;
                m_gcyc     = cyc;
                m_c        = req_central[m_w];
                m_r        = req_radius[m_w];
                m_m        = req_mode[m_w];
                m_ngnt++;
                glog.push_back(int'(m_w));
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    note_fail("unexpected_rsp");
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_candidate", 32'(rsp_candidate), 32'(e.cand));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_cycle", 32'(cyc), 32'(e.at));
                    m_ptr      = ~m_owner;
                    m_inflight = 1'b0;
                    m_nrsp++;
                end
            end else if (sb.size() != 0 && cyc >= sb[0].at) begin
                note_fail("rsp_missing");
                e = sb.pop_front();
                m_ptr      = ~m_owner;
                m_inflight = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int budget);
        int n0;
        n0 = m_ngnt;
        for (int i = 0; i < budget; i++) begin
            step();
            if (m_ngnt != n0) return;
        end
        note_fail("wait_gnt_timeout");
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (sb.size() == 0 && !m_inflight && !run_busy) return;
        end
        note_fail("drain_timeout");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_eng_en"}, 32'(eng_en), 32'h0);
        check({tag, "_eng_central"}, 32'(eng_central), 32'h0);
        check({tag, "_eng_radius"}, 32'(eng_radius), 32'h0);
        check({tag, "_eng_mode"}, 32'(eng_mode), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
        check({tag, "_rsp_candidate"}, 32'(rsp_candidate), 32'h0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; ext_busy = 1'b0; f_en = 1'b0; f_d = 0; f_c = 0;
        req_central = '0; req_radius = '0; req_mode = '0;
        repeat (3) step();
        req = 2'b11;                      // must not grant while in reset
        @(negedge clk);
        check_outputs_zero("reset");
        step();
        req = 2'b00;
        rst = 1'b0;
        step();

        // single job, requester 0, engine returns 13; req dropped after grant
        f_en = 1'b1; f_d = 2; f_c = 13;
        req_central[0] = 24'h440000; req_radius[0] = 12'h200; req_mode[0] = 2'd0;
        req_central[1] = 24'h123456; req_radius[1] = 12'h9ab; req_mode[1] = 2'd3;
        req = 2'b01;
        wait_gnt(20);
        req = 2'b00;
        drain(50);

        // reset in the middle of WAIT drops the job silently
        f_d = 6; f_c = 77;
        req = 2'b10;
        wait_gnt(20);
        req = 2'b00;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_outputs_zero("async_rst");
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b0;
        repeat (T + 4) step();

        // contention from pointer 0: grants alternate 0,1,0,1
        glog.delete();
        f_d = 1; f_c = 5;
        req = 2'b11;
        for (int i = 0; i < 200 && m_nrsp < 0 + 100000; i++) begin
            step();
            if (glog.size() >= 4 && !m_inflight) break;
        end
        req = 2'b00;
        drain(50);
        check("contention_count", 32'(glog.size() >= 4), 32'h1);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            check("contention_order", 32'(glog[i]), 32'(i % 2));
        end

        // busy gating: no grant while engine busy, grant the cycle it drops
        ext_busy = 1'b1;
        req = 2'b10;
        glog.delete();
        repeat (5) step();
        check("busy_no_gnt", 32'(glog.size()), 32'h0);
        ext_busy = 1'b0;
        step();
        check("busy_gnt_after", 32'(glog.size() == 1 && glog[0] == 1), 32'h1);
        req = 2'b00;
        drain(50);

        // timeout on requester 0, then contention must favour requester 1
        f_d = T + 2;
        req = 2'b01;
        wait_gnt(20);
        req = 2'b00;
        drain(60);
        glog.delete();
        f_d = 0; f_c = 9;
        req = 2'b11;
        wait_gnt(20);
        req = 2'b00;
        check("ptr_after_timeout", 32'(glog.size() == 1 && glog[0] == 1), 32'h1);
        drain(50);

        // boundary: strobe on the last WAIT cycle wins over the timeout
        f_d = T - 1; f_c = 8'hA5;
        req = 2'b10;
        wait_gnt(20);
        req = 2'b00;
        drain(60);

        // strobe one cycle too late: timeout, late strobe ignored
        f_d = T; f_c = 8'h3C;
        req = 2'b01;
        wait_gnt(20);
        req = 2'b00;
        drain(60);

        // random traffic
        f_en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step();
            req         = 2'($urandom);
            req_central = {16'($urandom), 32'($urandom)};
            req_radius  = 24'($urandom);
            req_mode    = 4'($urandom);
            ext_busy    = ($urandom_range(0, 9) == 0);
        end
        req = 2'b00;
        ext_busy = 1'b0;
        drain(200);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        check("responses_seen", 32'(m_nrsp > 10), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
